// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control FSM: opcodes, state
// encoding and the select/cause encodings driven onto the datapath.
package mc_ctrl_pkg;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpOp     = 7'b0110011;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StTrap
  } state_e;

  localparam logic [1:0] PcSelPlus4 = 2'd0;
  localparam logic [1:0] PcSelRel   = 2'd1;
  localparam logic [1:0] PcSelJalr  = 2'd2;

  localparam logic [1:0] WbSelAlu  = 2'd0;
  localparam logic [1:0] WbSelMem  = 2'd1;
  localparam logic [1:0] WbSelPc4  = 2'd2;
  localparam logic [1:0] WbSelImm  = 2'd3;

  localparam logic [1:0] CauseNone    = 2'd0;
  localparam logic [1:0] CauseIllegal = 2'd1;
  localparam logic [1:0] CauseBus     = 2'd2;

  function automatic logic is_legal(input logic [6:0] op);
    logic legal;
    unique case (op)
      OpLui, OpAuipc, OpJal, OpJalr, OpBranch,
      OpLoad, OpStore, OpOpImm, OpOp: legal = 1'b1;
      default:                         legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/mc_timeout.sv
// 8-bit wait counter shared by the FETCH and MEM handshakes; flags the cycle
// in which the Limit-th consecutive waiting cycle occurs.
module mc_timeout #(
  parameter int unsigned Limit = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [7:0] LastCnt = 8'(Limit - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 8'd0;
    end else if (en_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry is judged on the waiting cycle itself so the FSM can leave at once.
  assign expired_o = en_i && (cnt_q == LastCnt);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the RV32I core: sequences fetch, decode, execute,
// memory and writeback, counts retired instructions and traps on faults.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       fun3,
  input  logic             branch_taken,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             alu_a_sel,
  output logic             alu_b_sel,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             trap,
  output logic [1:0]       trap_cause
);

  state_e           state_q, state_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] instret_q;
  logic             tmo_clr, tmo_en, tmo_expired;

  // Sequencing depends on the opcode alone; fun3 is consumed by the datapath.
  logic unused_fun3;
  assign unused_fun3 = ^fun3;

  mc_timeout #(
    .Limit(MEM_TIMEOUT)
  ) u_timeout (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .clr_i    (tmo_clr),
    .en_i     (tmo_en),
    .expired_o(tmo_expired)
  );

  assign tmo_en  = ((state_q == StFetch) && !imem_ack) || ((state_q == StMem) && !dmem_ack);
  assign tmo_clr = (state_d != state_q) || imem_ack || dmem_ack;

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PcSelPlus4;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = WbSelAlu;
    retire    = 1'b0;
    trap      = 1'b0;

    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
      end

      StFetch: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_d = StDecode;
        end else if (tmo_expired) begin
          state_d = StTrap;
          cause_d = CauseBus;
        end
      end

      StDecode: begin
        if (!is_legal(opcode)) begin
          state_d = StTrap;
          cause_d = CauseIllegal;
        end else begin
          state_d = StExec;
        end
      end

      StExec: begin
        alu_a_sel = (opcode == OpAuipc) || (opcode == OpJal);
        alu_b_sel = !((opcode == OpOp) || (opcode == OpBranch));
        case (opcode)
          OpLoad, OpStore: state_d = StMem;
          OpBranch: begin
            pc_we   = 1'b1;
            pc_sel  = branch_taken ? PcSelRel : PcSelPlus4;
            retire  = 1'b1;
            state_d = StFetch;
          end
          default: state_d = StWb;
        endcase
      end

      StMem: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == OpStore);
        if (dmem_ack) begin
          if (opcode == OpStore) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end else if (tmo_expired) begin
          state_d = StTrap;
          cause_d = CauseBus;
        end
      end

      StWb: begin
        rf_we  = 1'b1;
        pc_we  = 1'b1;
        retire = 1'b1;
        case (opcode)
          OpJal:   pc_sel = PcSelRel;
          OpJalr:  pc_sel = PcSelJalr;
          default: pc_sel = PcSelPlus4;
        endcase
        case (opcode)
          OpLoad:        wb_sel = WbSelMem;
          OpJal, OpJalr: wb_sel = WbSelPc4;
          OpLui:         wb_sel = WbSelImm;
          default:       wb_sel = WbSelAlu;
        endcase
        state_d = StFetch;
      end

      StTrap: begin
        trap = 1'b1;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cause_q   <= CauseNone;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (retire) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  assign instret    = instret_q;
  assign trap_cause = cause_q;

endmodule
